// File: rtl/computer.sv
// Single-cycle 16-bit Hack-style CPU with zero-initialised ROM and RAM.
// Optional per-instruction trace when COMPUTER_TRACE_EN is defined.
module computer #(
  parameter int    ROM_WORDS = 1024,
  parameter int    RAM_WORDS = 1024,
  parameter string ROM_FILE  = "program.hex"
) (
  input  logic clk,
  input  logic reset,
  output logic ended
);

  localparam int ROM_AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [15:0] rom [0:ROM_WORDS-1];
  logic [15:0] ram [0:RAM_WORDS-1];

  // Memory images exist from time 0; reset never touches them.
  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ram[i] = 16'h0000;
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = 16'h0000;
  end

  logic [14:0] pc_reg, pc_next, pc_prev;
  logic [15:0] a_reg, a_next, d_reg, d_next;
  logic        ended_reg;
  logic [15:0] instr, prev_instr, m_val, x, y, out;
  logic        is_c, zr, ng, jump, self_jump, fall_off, halt_now, ram_ok, ram_we;
  logic        unused_bits;

  assign pc_prev     = pc_reg - 15'd1;
  assign is_c        = instr[15];
  assign unused_bits = &{1'b0, instr[14:13]};

  always_comb begin
    instr      = 16'h0000;
    prev_instr = 16'h0000;
    m_val      = 16'h0000;
    if (32'(pc_reg) < 32'(ROM_WORDS))  instr      = rom[pc_reg[ROM_AW-1:0]];
    if (32'(pc_prev) < 32'(ROM_WORDS)) prev_instr = rom[pc_prev[ROM_AW-1:0]];
    ram_ok = 32'(a_reg) < 32'(RAM_WORDS);
    if (ram_ok) m_val = ram[a_reg[RAM_AW-1:0]];
  end

  // ALU: zx nx zy ny f no in instr[11:6], y operand chosen by instr[12].
  always_comb begin
    x = d_reg;
    y = instr[12] ? m_val : a_reg;
    if (instr[11]) x = 16'h0000;
    if (instr[10]) x = ~x;
    if (instr[9])  y = 16'h0000;
    if (instr[8])  y = ~y;
    out = instr[7] ? (x + y) : (x & y);
    if (instr[6])  out = ~out;
    zr = (out == 16'h0000);
    ng = out[15];
  end

  always_comb begin
    jump      = is_c & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~zr & ~ng));
    // Halt idioms: jump to self, or jump back onto "@here-1" that reloads its own address.
    self_jump = jump && ((a_reg[14:0] == pc_reg) ||
                         ((a_reg[14:0] == pc_prev) && (prev_instr == {1'b0, pc_prev})));
    fall_off  = !jump && (32'(pc_reg) + 32'd1 == 32'(ROM_WORDS));
    halt_now  = !ended_reg && (self_jump || fall_off);

    pc_next = jump ? a_reg[14:0] : pc_reg + 15'd1;
    if (halt_now) pc_next = pc_reg;
    a_next = is_c ? (instr[5] ? out : a_reg) : {1'b0, instr[14:0]};
    d_next = (is_c && instr[4]) ? out : d_reg;
    ram_we = is_c && instr[3] && ram_ok && !ended_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= 15'd0;
      a_reg     <= 16'h0000;
      d_reg     <= 16'h0000;
      ended_reg <= 1'b0;
    end else if (!ended_reg) begin
      pc_reg    <= pc_next;
      a_reg     <= a_next;
      d_reg     <= d_next;
      ended_reg <= halt_now;
    end
  end

  // RAM write uses the pre-edge A as its address.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[a_reg[RAM_AW-1:0]] <= out;
  end

  assign ended = ended_reg;

`ifdef COMPUTER_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && !ended_reg) begin
      $display("PC=%0d instr=%04h A=%04h D=%04h out=%04h", pc_reg, instr, a_reg, d_reg, out);
      if (halt_now) $display("HALT at PC=%0d", pc_reg);
    end
  end
`endif

endmodule

// File: tb/tb_computer.sv
// Scoreboard bench for computer: directed programs poked into ROM, expected state queued
// by the stimulus and compared by an independent monitor process.
module tb_computer;
  localparam int ROMW = 64;
  localparam int RAMW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ended;

  computer #(.ROM_WORDS(ROMW), .RAM_WORDS(RAMW), .ROM_FILE("")) dut (
    .clk(clk), .reset(reset), .ended(ended)
  );

  always #5 clk = ~clk;

  localparam int K_PC = 0, K_A = 1, K_D = 2, K_END = 3, K_RAM = 4;

  // comp field codes (zx nx zy ny f no)
  localparam logic [5:0] C_ZERO = 6'b101010, C_ONE = 6'b111111, C_NEG1 = 6'b111010;
  localparam logic [5:0] C_D = 6'b001100, C_A = 6'b110000, C_NOTD = 6'b001101;
  localparam logic [5:0] C_NEGA = 6'b110011, C_DP1 = 6'b011111, C_AM1 = 6'b110010;
  localparam logic [5:0] C_DPA = 6'b000010, C_DMA = 6'b010011, C_DANDA = 6'b000000;
  localparam logic [5:0] C_DORA = 6'b010101;
  localparam logic [2:0] DN = 3'b000, DM = 3'b001, DD = 3'b010;
  localparam logic [2:0] JN = 3'b000, JEQ = 3'b010, JLT = 3'b100, JLE = 3'b110, JMP = 3'b111;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   req = 1'b0;

  function automatic logic [15:0] ai(input int v);
    return {1'b0, v[14:0]};
  endfunction

  function automatic logic [15:0] ci(input bit a, input logic [5:0] c, input logic [2:0] d,
                                     input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  function automatic logic [15:0] actual(input int kind, input int idx);
    case (kind)
      K_PC:    return {1'b0, dut.pc_reg};
      K_A:     return dut.a_reg;
      K_D:     return dut.d_reg;
      K_END:   return {15'd0, ended};
      default: return dut.ram[idx[3:0]];
    endcase
  endfunction

  // Monitor: drains the scoreboard each time the stimulus presents a sample point.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      wait (req);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = actual(e.kind, e.idx);
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end else begin
          $display("ok   %s = %h", e.name, act);
        end
      end
      req = 1'b0;
    end
  end

  task automatic expect_v(input string n, input int k, input int i, input logic [15:0] v);
    sb.push_back('{n, k, i, v});
  endtask

  task automatic sample();
    req = 1'b1;
    for (int i = 0; i < 3 && req; i++) #1;
    if (req) begin
      n_checks++;
      n_fail++;
      $display("FAIL monitor_timeout: got no response expected drain of %0d items", sb.size());
      sb.delete();
      req = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Loads a program while reset is held and checks the asynchronous reset state.
  task automatic load(input logic [15:0] p[$], input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < ROMW; i++) dut.rom[i[5:0]] = (i < p.size()) ? p[i] : 16'h0000;
    expect_v({tag, "_rst_pc"}, K_PC, 0, 16'd0);
    expect_v({tag, "_rst_end"}, K_END, 0, 16'd0);
    sample();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p[$];
    logic [5:0]  ops[7];
    logic [15:0] res[7];

    // Sum program: RAM[0]=2+3, halt via "@6; 0;JMP" at PC 7
    p = '{ai(2), ci(0, C_A, DD, JN), ai(3), ci(0, C_DPA, DD, JN),
          ai(0), ci(0, C_D, DM, JN), ai(6), ci(0, C_ZERO, DN, JMP)};
    load(p, "sum");
    step(7);
    expect_v("sum_not_ended_7", K_END, 0, 16'd0);
    sample();
    step(1);
    expect_v("sum_ended_8", K_END, 0, 16'd1);
    expect_v("sum_pc", K_PC, 0, 16'd7);
    expect_v("sum_ram0", K_RAM, 0, 16'd5);
    expect_v("sum_a", K_A, 0, 16'd6);
    sample();
    step(3);
    expect_v("sum_hold_pc", K_PC, 0, 16'd7);
    expect_v("sum_hold_d", K_D, 0, 16'd5);
    expect_v("sum_hold_end", K_END, 0, 16'd1);
    sample();

    // ALU ops with D=7, A=3 stored to RAM[1..7]
    ops = '{C_DMA, C_DANDA, C_DORA, C_NOTD, C_NEGA, C_DP1, C_AM1};
    res = '{16'd4, 16'd3, 16'd7, 16'hFFF8, 16'hFFFD, 16'd8, 16'd2};
    p.delete();
    for (int k = 0; k < 7; k++) begin
      p.push_back(ai(7));
      p.push_back(ci(0, C_A, DD, JN));
      p.push_back(ai(3));
      p.push_back(ci(0, ops[k], DD, JN));
      p.push_back(ai(k + 1));
      p.push_back(ci(0, C_D, DM, JN));
    end
    p.push_back(ai(42));
    p.push_back(ci(0, C_ZERO, DN, JMP));
    load(p, "alu");
    step(44);
    expect_v("alu_ended", K_END, 0, 16'd1);
    expect_v("alu_pc", K_PC, 0, 16'd43);
    for (int k = 0; k < 7; k++) expect_v($sformatf("alu_ram%0d", k + 1), K_RAM, k + 1, res[k]);
    sample();

    // Conditional jumps
    p.delete();
    for (int i = 0; i < 22; i++) p.push_back(16'h0000);
    p[0]  = ci(0, C_NEG1, DD, JN);
    p[1]  = ai(10);
    p[2]  = ci(0, C_D, DN, JLT);
    p[10] = ci(0, C_ONE, DD, JN);
    p[11] = ai(20);
    p[12] = ci(0, C_D, DN, JLE);
    p[13] = ci(0, C_ZERO, DD, JN);
    p[14] = ai(20);
    p[15] = ci(0, C_D, DN, JEQ);
    p[20] = ai(20);
    p[21] = ci(0, C_ZERO, DN, JMP);
    load(p, "jmp");
    step(3);
    expect_v("jlt_taken_pc", K_PC, 0, 16'd10);
    expect_v("jlt_d", K_D, 0, 16'hFFFF);
    sample();
    step(3);
    expect_v("jle_not_taken_pc", K_PC, 0, 16'd13);
    expect_v("jle_d", K_D, 0, 16'd1);
    sample();
    step(3);
    expect_v("jeq_taken_pc", K_PC, 0, 16'd20);
    sample();
    step(2);
    expect_v("jmp_ended", K_END, 0, 16'd1);
    expect_v("jmp_pc", K_PC, 0, 16'd21);
    sample();

    // Mid-run async reset, then out-of-range RAM access (A=20 >= RAM_WORDS)
    p = '{ai(9), ci(0, C_A, DD, JN), ai(0), ci(0, C_D, DM, JN), ai(3),
          ai(20), ci(0, C_ONE, DM, JN), ci(1, C_A, DD, JN), ai(8), ci(0, C_ZERO, DN, JMP)};
    load(p, "rst");
    step(5);
    expect_v("pre_rst_pc", K_PC, 0, 16'd5);
    expect_v("pre_rst_a", K_A, 0, 16'd3);
    expect_v("pre_rst_d", K_D, 0, 16'd9);
    sample();
    reset = 1'b1;
    #1;
    expect_v("async_rst_pc", K_PC, 0, 16'd0);
    expect_v("async_rst_a", K_A, 0, 16'd0);
    expect_v("async_rst_d", K_D, 0, 16'd0);
    expect_v("async_rst_end", K_END, 0, 16'd0);
    expect_v("async_rst_ram0", K_RAM, 0, 16'd9);
    sample();
    @(negedge clk);
    reset = 1'b0;
    step(10);
    expect_v("oor_ended", K_END, 0, 16'd1);
    expect_v("oor_pc", K_PC, 0, 16'd9);
    expect_v("oor_read_zero_d", K_D, 0, 16'd0);
    expect_v("oor_a", K_A, 0, 16'd8);
    expect_v("oor_ram4_untouched", K_RAM, 4, 16'hFFF8);
    sample();

    // All-@0 ROM: fall off the end after ROMW edges
    p.delete();
    load(p, "fall");
    step(ROMW - 1);
    expect_v("fall_not_ended", K_END, 0, 16'd0);
    expect_v("fall_pc_last", K_PC, 0, 16'(ROMW - 1));
    sample();
    step(1);
    expect_v("fall_ended", K_END, 0, 16'd1);
    expect_v("fall_a", K_A, 0, 16'd0);
    sample();
    step(2);
    expect_v("fall_hold_pc", K_PC, 0, 16'(ROMW - 1));
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
